regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL expose parameter DATA_WIDTH, default 32, meaning bit width of each register and data port.
REQ-002 SHALL expose parameter ADDR_WIDTH, default 5, meaning register index width; depth = 2**ADDR_WIDTH.
REQ-003 SHALL expose parameter A0_IDX, default 10, meaning index of the register mirrored on output a0.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, with ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- AD1  input  ADDR_WIDTH  read port 1 address.
- AD2  input  ADDR_WIDTH  read port 2 address.
- AD3  input  ADDR_WIDTH  write (writeback) address.
- WE3  input  1  write enable.
- WD3  input  DATA_WIDTH  write data.
- issue_valid  input  1  an instruction with destination issue_rd is issued this cycle.
- issue_rd  input  ADDR_WIDTH  destination of the issued instruction.
- RD1  output  DATA_WIDTH  registered read data, port 1.
- RD2  output  DATA_WIDTH  registered read data, port 2.
- busy1  output  1  combinational: AD1 has a pending (unwritten) result.
- busy2  output  1  combinational: AD2 has a pending result.
- pending_cnt  output  ADDR_WIDTH+1  number of registers currently marked busy.
- a0  output  DATA_WIDTH  combinational copy of register A0_IDX.

Function
REQ-005 Register 0 SHALL always read as zero; writes and issues to index 0 SHALL be ignored.
REQ-006 Reads SHALL have 1-cycle latency: RD1/RD2 update on each rising edge from the array at AD1/AD2.
REQ-007 When WE3=1 and AD3!=0, reg[AD3] SHALL take WD3 at the rising edge.
REQ-008 Scoreboard: one busy bit per register; issue_valid=1 with issue_rd!=0 SHALL set busy[issue_rd] at the edge.
REQ-009 WE3=1 with AD3!=0 SHALL clear busy[AD3] at the edge.
REQ-010 Simultaneous issue and write to the same index SHALL leave busy set (new issue wins).
REQ-011 Write of a non-busy register SHALL be permitted and leave busy clear.
REQ-012 busy1/busy2 SHALL be busy[AD1]/busy[AD2], always 0 for index 0.
REQ-013 pending_cnt SHALL equal population count of busy bits, updated in the same edge as busy; range 0..2**ADDR_WIDTH-1.
REQ-014 Issue to an already-busy register SHALL keep busy set and not change pending_cnt.
REQ-015 a0 SHALL reflect reg[A0_IDX] combinationally, including one cycle after a write.

Reset
REQ-016 rst=1 SHALL asynchronously clear all registers, all busy bits, RD1, RD2 and pending_cnt to 0; a0, busy1, busy2 read 0.
REQ-017 Writes and issues presented while rst=1 SHALL be discarded; normal operation resumes at the first edge after rst deasserts.

Configuration
REQ-018 Macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-019 With REGFILE_BYPASS_EN defined: if WE3=1, AD3!=0 and AD3==AD1 (resp. AD2), RD1 (resp. RD2) SHALL capture WD3; busy1/busy2 SHALL be masked to 0 for that matching write (unless issue_valid targets the same index).
REQ-020 Without REGFILE_BYPASS_EN: same-cycle read of the written index SHALL return the old value, and busy1/busy2 SHALL not be masked.

Verification
REQ-021 Reset mid-run: write 0xDEADBEEF to x5, issue x7, assert rst -> RD1, RD2, pending_cnt, a0 = 0 immediately; reading x5 after release returns 0.
REQ-022 x0: WE3=1, AD3=0, WD3=0xFFFFFFFF, issue_rd=0 -> AD1=0 reads 0, busy1=0, pending_cnt unchanged.
REQ-023 Forwarding: AD1=AD3=3, WE3=1, WD3=0x12345678, reg[3]=0x11 -> next cycle RD1=0x12345678 with macro, 0x11 without.
REQ-024 Scoreboard: issue x4, x6 on consecutive cycles -> pending_cnt 1 then 2; write x4 -> busy[4]=0, pending_cnt=1; simultaneous issue+write x6 -> busy[6] stays 1, pending_cnt=1.
REQ-025 Saturation: issue every index 1..31 -> pending_cnt=31; write all -> pending_cnt=0.
REQ-026 a0: write 0xCAFEF00D to x10 -> a0=0xCAFEF00D one edge later; write to x9 leaves a0 unchanged.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb -- register file with a per-register scoreboard.
//
// The register file has two registered read ports and one write
// (writeback) port. Each register also has a busy bit. An issue
// sets the busy bit of the destination register, and a writeback
// clears it. Register 0 always reads zero and is never marked busy.
//
// Parameters:
//   DATA_WIDTH  width of each register and data port
//   ADDR_WIDTH  register index width; depth = 2**ADDR_WIDTH
//   A0_IDX      index of the register mirrored on a0
//
// Optional feature:
//   REGFILE_BYPASS_EN  When defined, a write forwards to a read of the
//                      same index in the same cycle, and busy1/busy2 are
//                      masked for that index.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   AD1, AD2 -> RD1/2  read addresses and their registered read data
//   AD3, WE3, WD3      writeback address, enable and data
//   issue_valid/rd     issue of an instruction with destination issue_rd
//   busy1, busy2       combinational busy flags for AD1/AD2
//   pending_cnt        number of busy registers
//   a0                 combinational copy of register A0_IDX

// One register entry: the data word plus its busy bit.
module rf_entry #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  iss_en,
  input  logic [DATA_WIDTH-1:0] wd,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  busy,
  output logic                  busy_nxt
);
  // If an issue and a write hit the same register, the issue wins.
  // The new producer is still outstanding.
  always_comb begin
    busy_nxt = busy;
    if (wr_en)  busy_nxt = 1'b0;
    if (iss_en) busy_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      busy <= 1'b0;
    end else begin
      if (wr_en) data <= wd;
      busy <= busy_nxt;
    end
  end
endmodule

module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int A0_IDX     = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] AD1,
  input  logic [ADDR_WIDTH-1:0] AD2,
  input  logic [ADDR_WIDTH-1:0] AD3,
  input  logic                  WE3,
  input  logic [DATA_WIDTH-1:0] WD3,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2,
  output logic                  busy1,
  output logic                  busy2,
  output logic [ADDR_WIDTH:0]   pending_cnt,
  output logic [DATA_WIDTH-1:0] a0
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_nxt;
  logic                  wr_hit;
  logic                  iss_hit;
  logic [DATA_WIDTH-1:0] rd1_nxt;
  logic [DATA_WIDTH-1:0] rd2_nxt;
  logic [ADDR_WIDTH:0]   cnt_nxt;

  // Writes and issues to index 0 are dropped here. Entry 0 is also tied off.
  assign wr_hit  = WE3 && (AD3 != '0);
  assign iss_hit = issue_valid && (issue_rd != '0);

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    if (i == 0) begin : g_zero
      assign regs[i]     = '0;
      assign busy[i]     = 1'b0;
      assign busy_nxt[i] = 1'b0;
    end else begin : g_reg
      localparam logic [ADDR_WIDTH-1:0] IDX = ADDR_WIDTH'(i);
      rf_entry #(.DATA_WIDTH(DATA_WIDTH)) u_ent (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_hit && (AD3 == IDX)),
        .iss_en   (iss_hit && (issue_rd == IDX)),
        .wd       (WD3),
        .data     (regs[i]),
        .busy     (busy[i]),
        .busy_nxt (busy_nxt[i])
      );
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd1, fwd2;
  assign fwd1 = wr_hit && (AD3 == AD1);
  assign fwd2 = wr_hit && (AD3 == AD2);
  assign rd1_nxt = fwd1 ? WD3 : regs[AD1];
  assign rd2_nxt = fwd2 ? WD3 : regs[AD2];
  // A matching writeback resolves the hazard this cycle. A re-issue of
  // the same index in the same cycle keeps the register busy.
  assign busy1 = busy[AD1] & ~(fwd1 & ~(iss_hit && (issue_rd == AD1)));
  assign busy2 = busy[AD2] & ~(fwd2 & ~(iss_hit && (issue_rd == AD2)));
`else
  assign rd1_nxt = regs[AD1];
  assign rd2_nxt = regs[AD2];
  assign busy1   = busy[AD1];
  assign busy2   = busy[AD2];
`endif

  // The count is recomputed from the next busy vector. This keeps
  // pending_cnt exact and lets it change on the same edge as busy.
  always_comb begin
    cnt_nxt = '0;
    for (int k = 0; k < DEPTH; k++)
      cnt_nxt = cnt_nxt + {{ADDR_WIDTH{1'b0}}, busy_nxt[k]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RD1         <= '0;
      RD2         <= '0;
      pending_cnt <= '0;
    end else begin
      RD1         <= rd1_nxt;
      RD2         <= rd2_nxt;
      pending_cnt <= cnt_nxt;
    end
  end

  assign a0 = regs[A0_IDX];
endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] AD1 = '0, AD2 = '0, AD3 = '0, issue_rd = '0;
  logic          WE3 = 1'b0, issue_valid = 1'b0;
  logic [DW-1:0] WD3 = '0;
  logic [DW-1:0] RD1, RD2, a0;
  logic          busy1, busy2;
  logic [AW:0]   pending_cnt;

  regfile_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .A0_IDX(10)) dut (
    .clk(clk), .rst(rst), .AD1(AD1), .AD2(AD2), .AD3(AD3), .WE3(WE3),
    .WD3(WD3), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .RD1(RD1), .RD2(RD2), .busy1(busy1), .busy2(busy2),
    .pending_cnt(pending_cnt), .a0(a0)
  );

  always #5 clk = ~clk;

  // Reference model: the architectural register contents and the set of
  // registers that still await a result.
  logic [DW-1:0] mreg [N];
  bit            mbusy [N];
  logic [DW-1:0] m_rd1, m_rd2;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += mbusy[i] ? 1 : 0;
    return c;
  endfunction

  function automatic bit m_busy_view(input int a);
    bit b = mbusy[a];
    if (BYP && WE3 && AD3 != 0 && int'(AD3) == a && !(issue_valid && int'(issue_rd) == a))
      b = 1'b0;
    return b;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin mreg[i] = '0; mbusy[i] = 0; end
    m_rd1 = '0; m_rd2 = '0;
  endtask

  // Drive one cycle. The combinational busy flags are checked before the
  // edge. The registered outputs are checked just after it.
  task automatic step(input bit we, input int ad3, input logic [DW-1:0] wd,
                      input bit iv, input int ird, input int a1, input int a2);
    WE3 = we; AD3 = AW'(ad3); WD3 = wd;
    issue_valid = iv; issue_rd = AW'(ird);
    AD1 = AW'(a1); AD2 = AW'(a2);
    #1;
    chk("busy1", busy1, m_busy_view(a1));
    chk("busy2", busy2, m_busy_view(a2));
    @(posedge clk);
    m_rd1 = (BYP && we && ad3 != 0 && ad3 == a1) ? wd : mreg[a1];
    m_rd2 = (BYP && we && ad3 != 0 && ad3 == a2) ? wd : mreg[a2];
    if (we && ad3 != 0) begin mreg[ad3] = wd; mbusy[ad3] = 0; end
    if (iv && ird != 0) mbusy[ird] = 1;
    #1;
    chk("rd1", RD1, m_rd1);
    chk("rd2", RD2, m_rd2);
    chk("pending_cnt", pending_cnt, m_count());
    chk("a0", a0, mreg[10]);
  endtask

  initial begin
    m_reset();
    #12;
    chk("rst_rd1", RD1, 0);
    chk("rst_cnt", pending_cnt, 0);
    chk("rst_a0", a0, 0);
    @(negedge clk); rst = 1'b0;

    // Register x0 ignores both the write and the issue.
    step(1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("x0_rd", RD1, 0);
    chk("x0_busy", busy1, 0);
    chk("x0_cnt", pending_cnt, 0);

    // Scoreboard sequence.
    step(0, 0, 0, 1, 4, 4, 6);
    chk("sb_cnt1", pending_cnt, 1);
    step(0, 0, 0, 1, 6, 4, 6);
    chk("sb_cnt2", pending_cnt, 2);
    step(1, 4, 32'h44, 0, 0, 4, 6);
    chk("sb_cnt_w4", pending_cnt, 1);
    step(1, 6, 32'h66, 1, 6, 4, 6);
    chk("sb_cnt_iw6", pending_cnt, 1);
    step(0, 0, 0, 1, 6, 4, 6); // re-issue of a busy register
    chk("sb_reissue", pending_cnt, 1);
    #1 AD1 = 5'd6; AD2 = 5'd4; #1;
    chk("sb_busy6", busy1, 1);
    chk("sb_busy4", busy2, 0);

    // Same-cycle write and read of x3.
    step(1, 3, 32'h11, 0, 0, 0, 0);
    step(1, 3, 32'h1234_5678, 0, 0, 3, 3);
    chk("fwd_rd1", RD1, BYP ? 32'h1234_5678 : 32'h11);

    // The a0 output mirrors x10.
    step(1, 10, 32'hCAFE_F00D, 0, 0, 0, 0);
    chk("a0_w10", a0, 32'hCAFE_F00D);
    step(1, 9, 32'h9999_9999, 0, 0, 0, 0);
    chk("a0_w9", a0, 32'hCAFE_F00D);

    // Saturate the scoreboard, then drain it.
    for (int i = 1; i < N; i++) step(0, 0, 0, 1, i, i, 0);
    chk("sat31", pending_cnt, 31);
    for (int i = 1; i < N; i++) step(1, i, DW'($urandom), 0, 0, 0, i);
    chk("drain0", pending_cnt, 0);

    // Reset in the middle of the run.
    step(1, 5, 32'hDEAD_BEEF, 1, 7, 5, 10);
    step(0, 0, 0, 0, 0, 5, 7);
    WE3 = 1'b1; AD3 = 5'd5; WD3 = 32'h5555_5555; issue_valid = 1'b1; issue_rd = 5'd8;
    #1 rst = 1'b1; #1;
    chk("mrst_rd1", RD1, 0);
    chk("mrst_rd2", RD2, 0);
    chk("mrst_cnt", pending_cnt, 0);
    chk("mrst_a0", a0, 0);
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst = 1'b0;
    m_reset();
    step(0, 0, 0, 0, 0, 5, 8);
    chk("mrst_x5", RD1, 0);
    chk("mrst_cnt2", pending_cnt, 0);

    // Random traffic, with addresses biased toward collisions.
    for (int c = 0; c < 2000; c++) begin
      int lim = (c % 2) ? 31 : 7;
      step($urandom_range(0, 1), $urandom_range(0, lim), DW'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, lim),
           $urandom_range(0, lim), $urandom_range(0, lim));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
